// File: rtl/rx_lbuf_fill.sv
// rx_lbuf_fill -- consumer end of the RX lbuf grant interface.
//
// Takes one host large buffer (lbuf) at a time from the lbuf giver and carves
// it into DMA memory-write requests of up to CHUNK_QW qwords as RX data
// becomes available. Pulses lbuf_dn once the whole lbuf has been requested so
// the giver can hand over the next one.
//
// Optional feature macro: RX_LBUF_TIMEOUT_EN
//   defined   : a partial chunk that has sat unchanged for TIMEOUT cycles in
//               WAIT is flushed as a short request.
//   undefined : partial requests only happen as the last request of an lbuf.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   lbuf_addr     lbuf base byte address (4 KB aligned), valid while lbuf_en
//   lbuf_en       lbuf grant, held by the giver until it samples lbuf_dn
//   lbuf64b       base address has nonzero upper 32 bits
//   lbuf_dn       one-cycle pulse: current lbuf completely filled
//   rx_qw_avail   RX qwords buffered and not yet committed to a request
//   wr_req        write-request valid
//   wr_addr       request byte address
//   wr_64b        wr_addr needs a 4DW header
//   wr_len_qw     request length in qwords, 1..CHUNK_QW
//   wr_ack        request accepted
//   fsm_state     debug view of the control state
//
// Handshake: wr_req is a valid that, once raised, stays high with wr_addr,
// wr_64b and wr_len_qw frozen until a cycle in which wr_ack=1; the transfer
// happens on that edge and wr_req drops on it. wr_ack while wr_req=0 has no
// effect. Upstream removes wr_len_qw from rx_qw_avail the cycle after the ack.
// wr_len_qw is 8 bits wide, so CHUNK_QW must not exceed 255.
module rx_lbuf_fill #(
   parameter int LBUF_QW  = 131072,
   parameter int CHUNK_QW = 16,
   parameter int TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] lbuf_addr,
   input  logic        lbuf_en,
   input  logic        lbuf64b,
   output logic        lbuf_dn,
   input  logic [15:0] rx_qw_avail,
   output logic        wr_req,
   output logic [63:0] wr_addr,
   output logic        wr_64b,
   output logic [7:0]  wr_len_qw,
   input  logic        wr_ack,
   output logic [2:0]  fsm_state
);

   localparam int OW = $clog2(LBUF_QW) + 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_REQ  = 3'd2,
      S_NEXT = 3'd3,
      S_DONE = 3'd4,
      S_ACKW = 3'd5
   } state_t;

   state_t        state;
   logic [63:0]   base;
   logic          b64;
   logic [OW-1:0] offset;

   logic [31:0]   rem;
   logic [31:0]   n;
   logic [63:0]   next_addr;
   logic          full_chunk;
   logic          last_chunk;
   logic          fire;

`ifdef RX_LBUF_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] cnt;
   logic [15:0]   prev_avail;
   logic          partial;
   logic          avail_same;
   logic          flush;
`endif

   assign fsm_state = state;

   // n = min(rx_qw_avail, CHUNK_QW, rem), done in 32 bits so no operand wraps.
   always_comb begin
      rem = 32'(LBUF_QW) - 32'(offset);
      n   = {16'd0, rx_qw_avail};
      if (n > 32'(CHUNK_QW)) n = 32'(CHUNK_QW);
      if (n > rem) n = rem;
      next_addr  = base + {{(64-OW-3){1'b0}}, offset, 3'b000};
      full_chunk = (n == 32'(CHUNK_QW));
      last_chunk = (n == rem) && (n != 32'd0);
   end

`ifdef RX_LBUF_TIMEOUT_EN
   // A partial chunk is data that is neither a full chunk nor the lbuf tail;
   // it is only flushed after staying unchanged for TIMEOUT cycles.
   assign partial    = (n != 32'd0) && (n < 32'(CHUNK_QW)) && (n < rem);
   assign avail_same = (rx_qw_avail == prev_avail);
   assign flush      = partial && avail_same && (cnt == TW'(TIMEOUT));
   assign fire       = full_chunk || last_chunk || flush;
`else
   assign fire       = full_chunk || last_chunk;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         lbuf_dn   <= 1'b0;
         wr_req    <= 1'b0;
         wr_addr   <= '0;
         wr_64b    <= 1'b0;
         wr_len_qw <= '0;
         offset    <= '0;
         base      <= '0;
         b64       <= 1'b0;
`ifdef RX_LBUF_TIMEOUT_EN
         cnt        <= '0;
         prev_avail <= '0;
`endif
      end else begin
         lbuf_dn <= 1'b0;
`ifdef RX_LBUF_TIMEOUT_EN
         prev_avail <= rx_qw_avail;
`endif
         case (state)
            S_IDLE: begin
               if (lbuf_en) begin
                  base   <= lbuf_addr;
                  b64    <= lbuf64b;
                  offset <= '0;
                  state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (fire) begin
                  wr_req    <= 1'b1;
                  wr_len_qw <= n[7:0];
                  wr_addr   <= next_addr;
                  // b64 covers the base; the upper-word check covers a carry
                  // past 4 GB inside the lbuf.
                  wr_64b    <= b64 | (|next_addr[63:32]);
                  state     <= S_REQ;
               end
`ifdef RX_LBUF_TIMEOUT_EN
               if (fire || !partial || !avail_same) cnt <= '0;
               else                                 cnt <= cnt + 1'b1;
`endif
            end
            S_REQ: begin
               if (wr_ack) begin
                  wr_req <= 1'b0;
                  offset <= offset + OW'(wr_len_qw);
                  state  <= S_NEXT;
               end
            end
            // One spare cycle so rx_qw_avail reflects the accepted request
            // before WAIT samples it again.
            S_NEXT: begin
               if (offset == OW'(LBUF_QW)) state <= S_DONE;
               else                        state <= S_WAIT;
            end
            S_DONE: begin
               lbuf_dn <= 1'b1;
               state   <= S_ACKW;
            end
            // The giver still holds lbuf_en for the grant just finished; wait
            // for it to drop so the same grant is not taken twice.
            S_ACKW: begin
               if (!lbuf_en) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rx_lbuf_fill.sv
// tb_rx_lbuf_fill -- self-checking bench for rx_lbuf_fill.
//
// The reference model is the list of requests an lbuf must produce: chunk k
// sits at base + k*CHUNK*8 with length min(CHUNK, LBUF-k*CHUNK). An upstream
// RX model tracks buffered qwords, adds random data, and removes a request's
// length the cycle after its ack. Works with or without RX_LBUF_TIMEOUT_EN.
module tb_rx_lbuf_fill;

   localparam int LBUF  = 64;
   localparam int CHUNK = 16;
   localparam int TMO   = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] lbuf_addr;
   logic        lbuf_en;
   logic        lbuf64b;
   logic        lbuf_dn;
   logic [15:0] rx_qw_avail;
   logic        wr_req;
   logic [63:0] wr_addr;
   logic        wr_64b;
   logic [7:0]  wr_len_qw;
   logic        wr_ack;
   logic [2:0]  fsm_state;

   int n_checks = 0;
   int n_pass   = 0;
   int buffered = 0;

   rx_lbuf_fill #(
      .LBUF_QW  (LBUF),
      .CHUNK_QW (CHUNK),
      .TIMEOUT  (TMO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .lbuf_addr   (lbuf_addr),
      .lbuf_en     (lbuf_en),
      .lbuf64b     (lbuf64b),
      .lbuf_dn     (lbuf_dn),
      .rx_qw_avail (rx_qw_avail),
      .wr_req      (wr_req),
      .wr_addr     (wr_addr),
      .wr_64b      (wr_64b),
      .wr_len_qw   (wr_len_qw),
      .wr_ack      (wr_ack),
      .fsm_state   (fsm_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checker ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // ---------------- driver: serve one lbuf ----------------
   task automatic run_lbuf(input string tag, input logic [63:0] base,
                           input int ack_min, input int ack_max, input int feed_max);
      logic [63:0] ea[$];
      int          el[$];
      int          wait_ack = -1;
      int          dec = 0;
      int          cyc = 0;
      int          dn_seen = 0;
      for (int k = 0; k < LBUF; k += CHUNK) begin
         ea.push_back(base + 64'(k) * 64'd8);
         el.push_back((LBUF - k < CHUNK) ? (LBUF - k) : CHUNK);
      end
`ifdef RX_LBUF_TIMEOUT_EN
      buffered += LBUF;   // keep data ahead so no partial flush occurs
      rx_qw_avail = 16'(buffered);
`endif
      lbuf_addr = base;
      lbuf64b   = |base[63:32];
      lbuf_en   = 1'b1;
      while (dn_seen == 0 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         buffered -= dec;
         dec = 0;
         if (lbuf_dn) begin
            dn_seen = 1;
            chk({tag, " dn_after_all_reqs"}, 64'(ea.size()), 64'd0);
         end
         if (wr_req) begin
            if (ea.size() == 0) begin
               chk({tag, " extra_req"}, 64'(wr_req), 64'd0);
               wr_ack = 1'b0;
            end else begin
               chk({tag, " req_addr"}, wr_addr, ea[0]);
               chk({tag, " req_len"}, 64'(wr_len_qw), 64'(el[0]));
               chk({tag, " req_64b"}, 64'(wr_64b), 64'(|ea[0][63:32]));
               if (wait_ack < 0) begin
                  chk({tag, " req_has_data"}, 64'(buffered >= el[0]), 64'd1);
                  wait_ack = int'($urandom_range(ack_max, ack_min));
               end
               if (wait_ack == 0) begin
                  wr_ack = 1'b1;
                  dec = el[0];
                  void'(ea.pop_front());
                  void'(el.pop_front());
                  wait_ack = -1;
               end else begin
                  wr_ack = 1'b0;
                  wait_ack--;
               end
            end
         end else begin
            wr_ack = 1'($urandom_range(1, 0));   // stray acks must be ignored
         end
         if (buffered < 1000) buffered += int'($urandom_range(feed_max, 0));
         rx_qw_avail = 16'(buffered);
      end
      chk({tag, " dn_seen"}, 64'(dn_seen), 64'd1);
      wr_ack = 1'b0;
      buffered += 2 * CHUNK;   // data present: a re-used grant would show up
      rx_qw_avail = 16'(buffered);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk({tag, " dn_single_pulse"}, 64'(lbuf_dn), 64'd0);
         chk({tag, " no_req_while_held"}, 64'(wr_req), 64'd0);
      end
      lbuf_en = 1'b0;
      @(negedge clk);
      chk({tag, " no_req_after_release"}, 64'(wr_req), 64'd0);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [63:0] rb;
      int          any;
      int          got;
      int          cyc;

      // 1: reset with lbuf_en held high
      rst = 1'b1;
      lbuf_en = 1'b1;
      lbuf_addr = 64'h0000_0000_8000_0000;
      lbuf64b = 1'b0;
      wr_ack = 1'b0;
      buffered = 64;
      rx_qw_avail = 16'(buffered);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t1 rst_wr_req", 64'(wr_req), 64'd0);
         chk("t1 rst_lbuf_dn", 64'(lbuf_dn), 64'd0);
         chk("t1 rst_wr_addr", wr_addr, 64'd0);
         chk("t1 rst_wr_len", 64'(wr_len_qw), 64'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("t1 no_req_first_cycle", 64'(wr_req), 64'd0);

      // 2: grant already latched; full data, ack one cycle after wr_req
      run_lbuf("t2", 64'h0000_0000_8000_0000, 0, 0, 0);

      // 3: lbuf crossing 4 GB
      buffered = 0;
      rx_qw_avail = 16'(buffered);
      run_lbuf("t3", 64'h0000_0000_FFFF_FF80, 0, 0, 8);

      // 4: partial data held at 10 qwords
      lbuf_addr = 64'h0000_0000_2000_0000;
      lbuf64b = 1'b0;
      lbuf_en = 1'b1;
      buffered = 10;
      rx_qw_avail = 16'(buffered);
`ifndef RX_LBUF_TIMEOUT_EN
      any = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (wr_req) any = 1;
      end
      chk("t4 no_partial_req", 64'(any), 64'd0);
      buffered = 16;   // exactly one chunk: request must follow promptly
      rx_qw_avail = 16'(buffered);
      got = 0;
      for (int i = 0; i < 4; i++) begin
         if (got == 0) begin
            @(negedge clk);
            if (wr_req) got = 1;
         end
      end
      chk("t4 full_chunk_req", 64'(got), 64'd1);
      chk("t4 full_chunk_addr", wr_addr, 64'h0000_0000_2000_0000);
      chk("t4 full_chunk_len", 64'(wr_len_qw), 64'd16);
`else
      got = 0;
      cyc = 0;
      any = 0;
      for (int i = 0; i < 20; i++) begin
         if (got == 0) begin
            @(negedge clk);
            cyc++;
            if (wr_req) got = 1;
         end
      end
      chk("t4 flush_req", 64'(got), 64'd1);
      chk("t4 flush_len", 64'(wr_len_qw), 64'd10);
      chk("t4 flush_addr", wr_addr, 64'h0000_0000_2000_0000);
      chk("t4 flush_latency", 64'(cyc >= 9 && cyc <= 11), 64'd1);
`endif

      // 6: rst while a request is pending; same grant restarts at its base
      rst = 1'b1;
      @(negedge clk);
      chk("t6 rst_drops_req", 64'(wr_req), 64'd0);
      chk("t6 rst_clears_addr", wr_addr, 64'd0);
      chk("t6 rst_no_dn", 64'(lbuf_dn), 64'd0);
      rst = 1'b0;
      run_lbuf("t6", 64'h0000_0000_2000_0000, 0, 2, 6);

      // 5: slow acks, 64-bit base
      run_lbuf("t5", 64'h0000_0012_3456_7000, 5, 5, 4);

      // random grants
      for (int r = 0; r < 4; r++) begin
         rb = {32'($urandom), 32'($urandom)};
         if (r % 2 == 0) rb[63:32] = 32'd0;
         rb[11:0] = 12'd0;
         run_lbuf("rnd", rb, 0, 3, 6);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
